// File: rtl/conn_state_tracker_pkg.sv
// Shared state codes, interrupt bit indices and the FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conn_pkg;

    // Encoded connection state as seen by the downstream monitor.
    localparam logic [3:0] IDLE        = 4'd0;
    localparam logic [3:0] SYN_SENT    = 4'd1;
    localparam logic [3:0] ESTABLISHED = 4'd2;
    localparam logic [3:0] FIN_WAIT    = 4'd3;

    // Bit positions inside InterruptStatus.
    localparam int INT_CLOSED   = 0;
    localparam int INT_EST      = 1;
    localparam int INT_TIMEOUT  = 2;
    localparam int INT_PEER_RST = 3;

    // FSM state type; values track the encoded codes above so the state
    // register can drive ConnectionState directly.
    typedef enum logic [3:0] {
        ST_IDLE        = IDLE,
        ST_SYN_SENT    = SYN_SENT,
        ST_ESTABLISHED = ESTABLISHED,
        ST_FIN_WAIT    = FIN_WAIT
    } conn_state_t;

endpackage

// File: rtl/conn_state_tracker_if.sv
// Control/status bundle between the connection tracker and its neighbours.
// Latency: n/a (wiring only).
// Backpressure: none; all requests are levels or single-cycle pulses.
interface conn_state_tracker_if;

    // Requests and peer events towards the tracker.
    logic       open_req;
    logic       close_req;
    logic       rx_syn_ack;
    logic       rx_fin;
    logic       rx_rst;
    logic [3:0] int_clr;
    logic [3:0] int_en;

    // Link-layer pulses and status from the tracker.
    logic       tx_syn;
    logic       tx_ack;
    logic       tx_fin;
    logic [3:0] ConnectionState;
    logic [3:0] state;
    logic [3:0] InterruptStatus;
    logic       irq;
    logic [7:0] est_count;

    // Side that issues requests and observes status.
    modport master (
        output open_req, close_req, rx_syn_ack, rx_fin, rx_rst, int_clr, int_en,
        input  tx_syn, tx_ack, tx_fin, ConnectionState, state, InterruptStatus,
               irq, est_count
    );

    // The tracker itself.
    modport slave (
        input  open_req, close_req, rx_syn_ack, rx_fin, rx_rst, int_clr, int_en,
        output tx_syn, tx_ack, tx_fin, ConnectionState, state, InterruptStatus,
               irq, est_count
    );

endinterface

// File: rtl/conn_state_tracker_timer.sv
// Handshake timeout counter plus SYN retry counter for the connection FSM.
// Latency: expire is combinational from the registered count (flags the last cycle).
// Backpressure: none; counts freely while run is high, cleared by reload or !run.
module conn_timer #(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RETRY_MAX      = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,          // FSM is in a timed state
    input  logic reload,       // restart the timeout window this cycle
    input  logic retry,        // a retransmission is being issued
    output logic expire,       // this is the last cycle of the window
    output logic retries_left  // another retransmission is still allowed
);

    localparam int RTY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_LIM  = RTY_W'(RETRY_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [RTY_W-1:0] rty_q;

    // Timeout counter: held at zero outside timed states, restarted on reload.
    // Every expiry causes a reload or an exit, so it never needs to wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (reload || !run) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Retry counter: bumps on each retransmission, cleared on any fresh entry
    // into a timed state and whenever the FSM is untimed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rty_q <= '0;
        end else if (retry) begin
            rty_q <= rty_q + RTY_W'(1);
        end else if (reload || !run) begin
            rty_q <= '0;
        end
    end

    assign expire       = run && (cnt_q == CNT_LAST);
    assign retries_left = (rty_q < RTY_LIM);

endmodule

// File: rtl/conn_state_tracker.sv
// Connection-control FSM: state code, one-hot state, sticky interrupts, link pulses.
// Latency: all outputs registered; reactions appear one cycle after the input is sampled.
// Backpressure: none; events are pulses/levels, one transition per cycle by priority.
// Optional session counter on est_count is built when CONN_STATS_EN is defined.
module conn_state_tracker
    import conn_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8,
    parameter int RETRY_MAX      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    conn_state_tracker_if.slave   bus
);

    conn_state_t cur_st;
    conn_state_t nxt_st;

    logic [3:0] onehot_q;
    logic [3:0] is_q;
    logic [3:0] set_vec;
    logic       irq_q;
    logic       tx_syn_q;
    logic       tx_ack_q;
    logic       tx_fin_q;
    logic       tx_syn_nxt;
    logic       tx_ack_nxt;
    logic       tx_fin_nxt;

    logic       run;
    logic       reload;
    logic       retry;
    logic       expire;
    logic       retries_left;

    // Timer only advances in the two states that wait on the peer.
    assign run    = (cur_st == ST_SYN_SENT) || (cur_st == ST_FIN_WAIT);
    // Any state change starts a fresh window; a retry restarts it in place.
    assign reload = (nxt_st != cur_st) || retry;

    conn_timer #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .RETRY_MAX      (RETRY_MAX)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .reload       (reload),
        .retry        (retry),
        .expire       (expire),
        .retries_left (retries_left)
    );

    // Next-state, pulse and interrupt-set decode; priority is
    // rx_rst > rx_syn_ack/rx_fin > timeout > open_req/close_req.
    always_comb begin
        nxt_st     = cur_st;
        set_vec    = 4'b0000;
        tx_syn_nxt = 1'b0;
        tx_ack_nxt = 1'b0;
        tx_fin_nxt = 1'b0;
        retry      = 1'b0;
        unique case (cur_st)
            ST_IDLE: begin
                // Peer events are meaningless without a connection; close_req too.
                if (bus.open_req) begin
                    nxt_st     = ST_SYN_SENT;
                    tx_syn_nxt = 1'b1;
                end
            end
            ST_SYN_SENT: begin
                if (bus.rx_rst) begin
                    nxt_st                = ST_IDLE;
                    set_vec[INT_PEER_RST] = 1'b1;
                end else if (bus.rx_syn_ack) begin
                    nxt_st           = ST_ESTABLISHED;
                    tx_ack_nxt       = 1'b1;
                    set_vec[INT_EST] = 1'b1;
                end else if (expire) begin
                    if (retries_left) begin
                        retry      = 1'b1;
                        tx_syn_nxt = 1'b1;
                    end else begin
                        nxt_st               = ST_IDLE;
                        set_vec[INT_TIMEOUT] = 1'b1;
                    end
                end
            end
            ST_ESTABLISHED: begin
                if (bus.rx_rst) begin
                    nxt_st                = ST_IDLE;
                    set_vec[INT_PEER_RST] = 1'b1;
                end else if (bus.rx_fin) begin
                    nxt_st              = ST_IDLE;
                    tx_ack_nxt          = 1'b1;
                    set_vec[INT_CLOSED] = 1'b1;
                end else if (bus.close_req) begin
                    nxt_st     = ST_FIN_WAIT;
                    tx_fin_nxt = 1'b1;
                end
            end
            ST_FIN_WAIT: begin
                if (bus.rx_rst) begin
                    nxt_st                = ST_IDLE;
                    set_vec[INT_PEER_RST] = 1'b1;
                end else if (bus.rx_fin) begin
                    nxt_st              = ST_IDLE;
                    tx_ack_nxt          = 1'b1;
                    set_vec[INT_CLOSED] = 1'b1;
                end else if (expire) begin
                    nxt_st               = ST_IDLE;
                    set_vec[INT_TIMEOUT] = 1'b1;
                end
            end
            default: begin
                nxt_st = ST_IDLE;
            end
        endcase
    end

    // State register with a registered one-hot copy for bit-indexed consumers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_st   <= ST_IDLE;
            onehot_q <= 4'b0001;
        end else begin
            cur_st   <= nxt_st;
            onehot_q <= 4'b0001 << nxt_st;
        end
    end

    // Link-layer pulses, registered so each is exactly one cycle wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_syn_q <= 1'b0;
            tx_ack_q <= 1'b0;
            tx_fin_q <= 1'b0;
        end else begin
            tx_syn_q <= tx_syn_nxt;
            tx_ack_q <= tx_ack_nxt;
            tx_fin_q <= tx_fin_nxt;
        end
    end

    // Sticky interrupt bits: a new event beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_q <= 4'b0000;
        end else begin
            is_q <= (is_q & ~bus.int_clr) | set_vec;
        end
    end

    // irq follows the status register one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(is_q & bus.int_en);
        end
    end

`ifdef CONN_STATS_EN
    logic [7:0] est_q;
    logic       est_inc;

    assign est_inc = (cur_st == ST_SYN_SENT) && (nxt_st == ST_ESTABLISHED);

    // Saturating count of completed opens; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            est_q <= 8'd0;
        end else if (est_inc && (est_q != 8'hFF)) begin
            est_q <= est_q + 8'd1;
        end
    end

    assign bus.est_count = est_q;
`else
    assign bus.est_count = 8'd0;
`endif

    assign bus.ConnectionState = cur_st;
    assign bus.state           = onehot_q;
    assign bus.InterruptStatus = is_q;
    assign bus.irq             = irq_q;
    assign bus.tx_syn          = tx_syn_q;
    assign bus.tx_ack          = tx_ack_q;
    assign bus.tx_fin          = tx_fin_q;

endmodule

// File: tb/tb_conn_state_tracker.sv
// Directed bench for conn_state_tracker with a short timeout (4 cycles, 3 retries).
// Inputs change 1 time unit after a rising edge; outputs are checked at that point.
// Each comparison is an immediate assertion that counts and reports failures.
module tb_conn_state_tracker;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   exp_est;

    conn_state_tracker_if bus ();

    conn_state_tracker #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8),
        .RETRY_MAX      (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Open a connection and complete it on the next cycle.
    task automatic go_est();
        bus.open_req = 1'b1;
        tick();
        bus.open_req   = 1'b0;
        bus.rx_syn_ack = 1'b1;
        tick();
        bus.rx_syn_ack = 1'b0;
`ifdef CONN_STATS_EN
        if (exp_est < 255) exp_est++;
`endif
        check("go_est_cs", {4'd0, bus.ConnectionState}, 8'd2);
    endtask

    task automatic clear_all();
        bus.int_clr = 4'hF;
        tick();
        bus.int_clr = 4'h0;
        check("clear_is", {4'd0, bus.InterruptStatus}, 8'd0);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        exp_est = 0;
        rst_n          = 1'b0;
        bus.open_req   = 1'b0;
        bus.close_req  = 1'b0;
        bus.rx_syn_ack = 1'b0;
        bus.rx_fin     = 1'b0;
        bus.rx_rst     = 1'b0;
        bus.int_clr    = 4'h0;
        bus.int_en     = 4'h0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_cs",  {4'd0, bus.ConnectionState}, 8'd0);
        check("rst_oh",  {4'd0, bus.state}, 8'd1);
        check("rst_is",  {4'd0, bus.InterruptStatus}, 8'd0);
        check("rst_tx",  {5'd0, bus.tx_syn, bus.tx_ack, bus.tx_fin}, 8'd0);
        check("rst_irq", {7'd0, bus.irq}, 8'd0);
        check("rst_est", bus.est_count, 8'd0);
        rst_n = 1'b1;
        tick();

        // Peer events in IDLE are ignored.
        bus.rx_syn_ack = 1'b1;
        bus.rx_fin     = 1'b1;
        tick();
        bus.rx_syn_ack = 1'b0;
        bus.rx_fin     = 1'b0;
        check("idle_ign_cs", {4'd0, bus.ConnectionState}, 8'd0);
        check("idle_ign_tx", {5'd0, bus.tx_syn, bus.tx_ack, bus.tx_fin}, 8'd0);

        // Reset asserted in the middle of SYN_SENT.
        bus.open_req = 1'b1;
        tick();
        bus.open_req = 1'b0;
        check("open_cs", {4'd0, bus.ConnectionState}, 8'd1);
        check("open_syn", {7'd0, bus.tx_syn}, 8'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_cs", {4'd0, bus.ConnectionState}, 8'd0);
        check("midrst_oh", {4'd0, bus.state}, 8'd1);
        check("midrst_is", {4'd0, bus.InterruptStatus}, 8'd0);
        check("midrst_tx", {5'd0, bus.tx_syn, bus.tx_ack, bus.tx_fin}, 8'd0);
        rst_n = 1'b1;
        tick();
        check("postrst_cs", {4'd0, bus.ConnectionState}, 8'd0);
        check("postrst_tx", {5'd0, bus.tx_syn, bus.tx_ack, bus.tx_fin}, 8'd0);

        // Open, SYN-ACK two cycles later, irq enabled for ESTABLISHED.
        bus.int_en   = 4'b0010;
        bus.open_req = 1'b1;
        tick();
        bus.open_req = 1'b0;
        check("est_syn1", {7'd0, bus.tx_syn}, 8'd1);
        tick();
        check("est_syn0", {7'd0, bus.tx_syn}, 8'd0);
        check("est_wait_cs", {4'd0, bus.ConnectionState}, 8'd1);
        bus.rx_syn_ack = 1'b1;
        tick();
        bus.rx_syn_ack = 1'b0;
`ifdef CONN_STATS_EN
        exp_est++;
`endif
        check("est_cs",   {4'd0, bus.ConnectionState}, 8'd2);
        check("est_oh",   {4'd0, bus.state}, 8'h04);
        check("est_ack",  {7'd0, bus.tx_ack}, 8'd1);
        check("est_is",   {4'd0, bus.InterruptStatus}, 8'h02);
        check("est_irq0", {7'd0, bus.irq}, 8'd0);
        tick();
        check("est_ack0", {7'd0, bus.tx_ack}, 8'd0);
        check("est_irq1", {7'd0, bus.irq}, 8'd1);
        check("est_cnt",  bus.est_count, 8'(exp_est));

        // Local close then peer FIN.
        bus.close_req = 1'b1;
        tick();
        bus.close_req = 1'b0;
        check("close_cs",  {4'd0, bus.ConnectionState}, 8'd3);
        check("close_oh",  {4'd0, bus.state}, 8'h08);
        check("close_fin", {7'd0, bus.tx_fin}, 8'd1);
        tick();
        check("close_fin0", {7'd0, bus.tx_fin}, 8'd0);
        bus.rx_fin = 1'b1;
        tick();
        bus.rx_fin = 1'b0;
        check("fin_cs",  {4'd0, bus.ConnectionState}, 8'd0);
        check("fin_ack", {7'd0, bus.tx_ack}, 8'd1);
        check("fin_is",  {4'd0, bus.InterruptStatus}, 8'h03);

        // Clearing status drops irq one cycle later.
        clear_all();
        tick();
        check("irq_clr", {7'd0, bus.irq}, 8'd0);
        bus.int_en = 4'h0;

        // No response: SYN at 0,4,8,12 then timeout into IDLE at 16.
        bus.open_req = 1'b1;
        tick();
        bus.open_req = 1'b0;
        check("to_syn0", {7'd0, bus.tx_syn}, 8'd1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("to_syn%0d", k), {7'd0, bus.tx_syn},
                  ((k % 4 == 0) && (k < 16)) ? 8'd1 : 8'd0);
            check($sformatf("to_cs%0d", k), {4'd0, bus.ConnectionState},
                  (k < 16) ? 8'd1 : 8'd0);
        end
        check("to_is", {4'd0, bus.InterruptStatus}, 8'h04);
        clear_all();

        // Peer reset and FIN together in ESTABLISHED: reset wins.
        go_est();
        bus.rx_rst  = 1'b1;
        bus.rx_fin  = 1'b1;
        bus.int_clr = 4'b0010;
        tick();
        bus.rx_rst  = 1'b0;
        bus.rx_fin  = 1'b0;
        bus.int_clr = 4'h0;
        check("rstfin_cs",  {4'd0, bus.ConnectionState}, 8'd0);
        check("rstfin_is",  {4'd0, bus.InterruptStatus}, 8'h08);
        check("rstfin_ack", {7'd0, bus.tx_ack}, 8'd0);
        clear_all();

        // Set and clear of CLOSED in the same cycle keeps it set.
        go_est();
        bus.rx_fin  = 1'b1;
        bus.int_clr = 4'b0011;
        tick();
        bus.rx_fin  = 1'b0;
        bus.int_clr = 4'h0;
        check("setclr_is",  {4'd0, bus.InterruptStatus}, 8'h01);
        check("setclr_ack", {7'd0, bus.tx_ack}, 8'd1);
        clear_all();

        // FIN_WAIT times out with no retry.
        go_est();
        bus.close_req = 1'b1;
        tick();
        bus.close_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("fw_cs%0d", k), {4'd0, bus.ConnectionState},
                  (k < 4) ? 8'd3 : 8'd0);
            check($sformatf("fw_fin%0d", k), {7'd0, bus.tx_fin}, 8'd0);
        end
        check("fw_is", {4'd0, bus.InterruptStatus}, 8'h06);
        clear_all();

        // rx_fin ignored in SYN_SENT, then peer reset aborts.
        bus.open_req = 1'b1;
        tick();
        bus.open_req = 1'b0;
        bus.rx_fin   = 1'b1;
        tick();
        bus.rx_fin = 1'b0;
        check("ss_fin_cs",  {4'd0, bus.ConnectionState}, 8'd1);
        check("ss_fin_ack", {7'd0, bus.tx_ack}, 8'd0);
        bus.rx_rst = 1'b1;
        tick();
        bus.rx_rst = 1'b0;
        check("ss_rst_cs", {4'd0, bus.ConnectionState}, 8'd0);
        check("ss_rst_is", {4'd0, bus.InterruptStatus}, 8'h08);
        clear_all();

        // open_req and close_req together in IDLE: open wins.
        bus.open_req  = 1'b1;
        bus.close_req = 1'b1;
        tick();
        bus.open_req  = 1'b0;
        bus.close_req = 1'b0;
        check("oc_cs",  {4'd0, bus.ConnectionState}, 8'd1);
        check("oc_syn", {7'd0, bus.tx_syn}, 8'd1);
        check("oc_fin", {7'd0, bus.tx_fin}, 8'd0);
        bus.rx_rst = 1'b1;
        tick();
        bus.rx_rst = 1'b0;
        clear_all();

`ifdef CONN_STATS_EN
        // Enough sessions to saturate the counter.
        for (int s = 0; s < 300; s++) begin
            go_est();
            bus.rx_rst = 1'b1;
            tick();
            bus.rx_rst = 1'b0;
        end
        check("est_sat_model", 8'(exp_est), 8'd255);
`endif
        check("est_final", bus.est_count, 8'(exp_est));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conn_state_tracker.md
Name: conn_state_tracker

Overview:
- Connection-control FSM that produces the 4-bit ConnectionState code, the one-hot state vector and the sticky InterruptStatus register.
- The downstream monitor stage consumes these outputs. It compares ConnectionState against ESTABLISHED, tests InterruptStatus[0], and indexes state bits by state constant.
- Drives handshake pulses towards the link layer and runs a handshake timeout with bounded retries.

Parameters:
- TIMEOUT_CYCLES, 255: cycles spent in SYN_SENT or FIN_WAIT before a timeout event; legal range 2..2**CNT_W-1.
- CNT_W, 8: width of the timeout counter.
- RETRY_MAX, 3: number of SYN retransmissions before giving up.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- open_req  in  1  request to open a connection; level, sampled in IDLE only.
- close_req  in  1  request to close; sampled in ESTABLISHED only.
- rx_syn_ack  in  1  peer SYN-ACK received; 1-cycle pulse.
- rx_fin  in  1  peer FIN received; 1-cycle pulse.
- rx_rst  in  1  peer RESET received; 1-cycle pulse.
- int_clr  in  4  write-1-to-clear for InterruptStatus.
- int_en  in  4  per-bit interrupt enable.
- tx_syn  out  1  send SYN; 1-cycle pulse.
- tx_ack  out  1  send ACK; 1-cycle pulse.
- tx_fin  out  1  send FIN; 1-cycle pulse.
- ConnectionState  out  4  encoded state: IDLE=0, SYN_SENT=1, ESTABLISHED=2, FIN_WAIT=3; upper codes unused.
- state  out  4  one-hot copy, state[k] set when ConnectionState==k.
- InterruptStatus  out  4  sticky bits: [0] CLOSED, [1] ESTABLISHED, [2] TIMEOUT, [3] PEER_RESET.
- irq  out  1  OR of (InterruptStatus & int_en).
- est_count  out  8  established-session counter (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): ConnectionState=0, state=4'b0001, InterruptStatus=0, all tx_* low, irq=0, timer=0, retry=0, est_count=0. Assertion mid-handshake aborts immediately with no pulses.
- All outputs are registered. Pulses and interrupt bits appear the cycle after the triggering input is sampled.
- Event priority within a state, highest first: rx_rst, then rx_syn_ack/rx_fin, then timeout, then open_req/close_req. Only one transition per cycle.
- IDLE:
  - open_req -> SYN_SENT; tx_syn pulse; timer=0; retry=0.
  - rx_* inputs in IDLE are ignored.
- SYN_SENT:
  - rx_rst -> IDLE; set IS[3].
  - rx_syn_ack -> ESTABLISHED; tx_ack pulse; set IS[1].
  - timer==TIMEOUT_CYCLES-1 and retry<RETRY_MAX -> stay in SYN_SENT; retry+1; timer=0; tx_syn pulse.
  - timer==TIMEOUT_CYCLES-1 and retry==RETRY_MAX -> IDLE; set IS[2].
  - rx_fin is ignored.
- ESTABLISHED:
  - rx_rst -> IDLE; set IS[3].
  - rx_fin -> IDLE; tx_ack pulse; set IS[0].
  - close_req -> FIN_WAIT; tx_fin pulse; timer=0.
  - Timer is held at 0.
- FIN_WAIT:
  - rx_rst -> IDLE; set IS[3].
  - rx_fin -> IDLE; tx_ack pulse; set IS[0].
  - timer==TIMEOUT_CYCLES-1 -> IDLE; set IS[2]. No retries in FIN_WAIT.
- Timer increments by 1 per cycle in SYN_SENT and FIN_WAIT and never wraps, because the timeout handler reloads it.
- InterruptStatus: IS <= (IS & ~int_clr) | set_vec. A set and a clear of the same bit in the same cycle leaves the bit set.
- irq is registered and follows IS by one cycle.
- Simultaneous open_req and close_req in IDLE: open_req wins; close_req is ignored.

Optional Feature:
- Macro CONN_STATS_EN.
- Defined: est_count increments on every SYN_SENT->ESTABLISHED transition and saturates at 255. It is cleared only by reset.
- Undefined: est_count is tied to 8'd0 and no counter flops are generated. The port list is identical in both builds.

Decomposition:
- Package conn_pkg holds:
  - State code localparams IDLE, SYN_SENT, ESTABLISHED, FIN_WAIT (4-bit).
  - Interrupt bit indices INT_CLOSED=0, INT_EST=1, INT_TIMEOUT=2, INT_PEER_RST=3.
  - The 4-bit state typedef.
- Sub-module conn_timer holds the CNT_W timer and retry counter. Inputs: run, reload. Outputs: expire, retries_left.
- The FSM, interrupt register and pulse generation stay in the top module.

Test Plan:
- Reset mid-SYN_SENT (open_req, then rst_n low for 1 cycle) -> ConnectionState=0, state=4'b0001, IS=0, no tx pulses.
- Open, then rx_syn_ack 5 cycles later -> tx_syn at cycle 1; ConnectionState=2, state=4'b0100, tx_ack pulse, IS=4'b0010; irq=1 if int_en[1].
- Open with no response, TIMEOUT_CYCLES=4, RETRY_MAX=3 -> 4 tx_syn pulses spaced 4 cycles apart, then IDLE with IS[2]=1.
- ESTABLISHED, close_req, then rx_fin -> tx_fin, then tx_ack; ConnectionState 2->3->0; IS[0]=1.
- rx_rst and rx_fin in the same cycle in ESTABLISHED -> IDLE, IS[3]=1, IS[0]=0, no tx_ack.
- int_clr=4'b0001 in the same cycle IS[0] is set -> IS[0] stays 1. With CONN_STATS_EN, 300 sessions -> est_count=255.
